// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter stage feeding the fetch stage's proCount_in.
// Issues one fetch address per clock when running; handles stall, redirect,
// halt/resume and, when PC_SEQ_RAS_EN is defined, a return-address stack for
// CALL/RET with sticky overflow/underflow flags. All outputs are registered.
module pc_sequencer #(
   parameter int unsigned     PC_W      = 19,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter int unsigned     RAS_DEPTH = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_target,
   input  logic            call,
   input  logic [PC_W-1:0] link_addr,
   input  logic            ret,
   input  logic            halt,
   input  logic            resume,
   output logic [PC_W-1:0] pc_out,
   output logic            pc_valid,
   output logic            halted,
   output logic            ras_overflow,
   output logic            ras_underflow
);

   typedef enum logic [1:0] {StRun, StStall, StHalt} state_t;

   state_t          r_state;
   logic [PC_W-1:0] r_pc;
   logic            r_valid;
   logic            r_halted;

   logic [PC_W-1:0] w_pc_inc;
   logic            w_active;
   logic            w_ret_en;
   logic [PC_W-1:0] w_ret_pc;

   assign w_pc_inc = r_pc + 1'b1;
   assign w_active = (r_state != StHalt);

`ifdef PC_SEQ_RAS_EN
   localparam int unsigned   PtrW     = $clog2(RAS_DEPTH);
   localparam logic [PtrW:0] DepthCnt = RAS_DEPTH[PtrW:0];

   logic [PC_W-1:0] r_ras [RAS_DEPTH];
   logic [PtrW-1:0] r_ptr;   // next slot to write; top of stack is r_ptr-1
   logic [PtrW:0]   r_cnt;
   logic            r_ovf;
   logic            r_udf;

   logic [PtrW-1:0] w_ptr_dec;
   logic            w_empty;
   logic            w_full;
   logic            w_push;
   logic            w_pop;
   logic            w_udf_set;

   assign w_ptr_dec = r_ptr - 1'b1;
   assign w_empty   = (r_cnt == '0);
   assign w_full    = (r_cnt == DepthCnt);
   assign w_ret_en  = ret;
   // Pop on empty stack degrades to a plain increment
   assign w_ret_pc  = w_empty ? w_pc_inc : r_ras[w_ptr_dec];

   assign w_push    = w_active & ~halt & ~ret & redirect_valid & call;
   assign w_pop     = w_active & ~halt & ret & ~w_empty;
   assign w_udf_set = w_active & ~halt & ret & w_empty;

   // Return-address stack: circular buffer, push overwrites oldest when full
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            r_ras[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_ras[r_ptr] <= link_addr;
            r_ptr        <= r_ptr + 1'b1;
            if (w_full) begin
               r_ovf <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else if (w_pop) begin
            r_ptr <= w_ptr_dec;
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_udf_set) begin
            r_udf <= 1'b1;
         end
      end
   end

   assign ras_overflow  = r_ovf;
   assign ras_underflow = r_udf;
`else
   logic w_unused;

   // Without the stack, call and ret carry no meaning
   assign w_unused      = ^{call, ret, link_addr};
   assign w_ret_en      = 1'b0;
   assign w_ret_pc      = w_pc_inc;
   assign ras_overflow  = 1'b0;
   assign ras_underflow = 1'b0;
`endif

   // Control FSM with registered PC, valid and halted outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= StRun;
         r_pc     <= RESET_PC;
         r_valid  <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         case (r_state)
            StHalt: begin
               if (resume && !halt) begin
                  r_state  <= StRun;
                  r_pc     <= w_pc_inc;
                  r_valid  <= 1'b1;
                  r_halted <= 1'b0;
               end else begin
                  r_valid  <= 1'b0;
                  r_halted <= 1'b1;
               end
            end
            default: begin
               if (halt) begin
                  r_state  <= StHalt;
                  r_valid  <= 1'b0;
                  r_halted <= 1'b1;
               end else if (w_ret_en) begin
                  r_state <= StRun;
                  r_pc    <= w_ret_pc;
                  r_valid <= 1'b1;
               end else if (redirect_valid) begin
                  r_state <= StRun;
                  r_pc    <= redirect_target;
                  r_valid <= 1'b1;
               end else if (stall) begin
                  r_state <= StStall;
                  r_valid <= 1'b0;
               end else begin
                  r_state <= StRun;
                  r_pc    <= w_pc_inc;
                  r_valid <= 1'b1;
               end
            end
         endcase
      end
   end

   assign pc_out   = r_pc;
   assign pc_valid = r_valid;
   assign halted   = r_halted;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter stage sitting directly upstream of the instruction fetch stage: it generates the 19-bit fetch address each cycle and drives the fetch stage's `proCount_in`. It handles sequential increment, stall, branch/jump redirect, halt/resume, and an optional return-address stack for CALL/RET. All outputs are registered; one PC is issued per clock when running.

## Interface
- `PC_W`, 19, PC and address width; must match instruction width of fetch stage
- `RESET_PC`, 19'd0, PC value loaded on reset
- `RAS_DEPTH`, 8, return-address stack entries; power of two, 2..32
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset; one clock; reset asserted when `reset`=0
- `stall`  in  1  hold current PC (downstream not ready)
- `redirect_valid`  in  1  load `redirect_target` as next PC
- `redirect_target`  in  PC_W  branch/jump/call target
- `call`  in  1  qualifies redirect as CALL: push `link_addr`
- `link_addr`  in  PC_W  return address to push (decode supplies address after CALL)
- `ret`  in  1  RET: pop stack top as next PC
- `halt`  in  1  enter HALT
- `resume`  in  1  leave HALT
- `pc_out`  out  PC_W  fetch address, to fetch stage `proCount_in`
- `pc_valid`  out  1  `pc_out` is a new, valid fetch address this cycle
- `halted`  out  1  state is HALT
- `ras_overflow`  out  1  sticky: push occurred with stack full
- `ras_underflow`  out  1  sticky: RET occurred with stack empty

## Operation
- FSM states: RUN, STALL, HALT. Reset state RUN.
- Per-edge priority (highest first): halt, ret, redirect_valid, stall, increment.
- RUN/STALL, `halt`=1: -> HALT; `pc_out` holds; all other inputs that cycle ignored (no push/pop).
- `ret`=1: `pc_out` <= stack top, pointer decrements; -> RUN. If `redirect_valid` also 1, redirect ignored.
- `redirect_valid`=1: `pc_out` <= `redirect_target`; -> RUN. If `call`=1, push `link_addr`. `call` without `redirect_valid` ignored.
- redirect/ret take effect even when `stall`=1 (control transfer never lost).
- `stall`=1 otherwise: `pc_out` holds; -> STALL.
- Otherwise: `pc_out` <= `pc_out` + 1, modulo 2^PC_W (0x7FFFF -> 0x00000, no flag).
- HALT: `pc_out` holds; `resume`=1 -> RUN with `pc_out` <= `pc_out` + 1; `halt` and `resume` both 1 -> stay HALT.
- Stack: circular buffer, `RAS_DEPTH` entries, count 0..RAS_DEPTH.
  - Push when full: overwrite oldest entry, count stays RAS_DEPTH, set `ras_overflow`.
  - Pop when empty: `pc_out` <= `pc_out` + 1 (treated as increment), pointer unchanged, set `ras_underflow`.
- Sticky flags clear only on reset.

## Timing
- Reset values: `pc_out`=RESET_PC, `pc_valid`=0, `halted`=0, both flags 0, stack count 0, state RUN.
- First edge with `reset`=1: `pc_out` = RESET_PC+1 unless stalled, `pc_valid`=1; RESET_PC itself is presented (with `pc_valid`=0) only during reset, so the first fetched PC is RESET_PC via the fetch register on that first edge.
- Latency: input sampled at edge N is reflected on `pc_out` after edge N (one cycle).
- `pc_valid` registered: 1 after any edge that loaded a new PC (increment, redirect, ret, resume); 0 after edges in STALL hold or HALT.
- `halted` = 1 in the cycle after the edge entering HALT, through the edge taking `resume`.
- Reset assertion mid-operation: all state cleared immediately (asynchronous), stack contents discarded, in-flight redirect lost.

## Configuration
- `PC_SEQ_RAS_EN` defined: return-address stack, `call` push, `ret` pop and both sticky flags implemented as above.
- Not defined: no stack storage; `call` ignored (redirect still taken), `ret` treated as plain increment (lowest-priority path applies), `ras_overflow`/`ras_underflow` tied 0.

## Test plan
- Reset release, no other inputs, 4 cycles -> `pc_out` 0x00001, 0x00002, 0x00003, 0x00004; `pc_valid`=1 each.
- `stall`=1 for 3 cycles at `pc_out`=0x00005 -> holds 0x00005, `pc_valid`=0; `stall` + `redirect_valid` target 0x00100 same cycle -> 0x00100 next.
- CALL: redirect 0x00200, `call`=1, `link_addr`=0x00011; later `ret`=1 -> `pc_out`=0x00011; second `ret` -> `ras_underflow`=1, `pc_out` increments.
- 9 CALLs (RAS_DEPTH=8) link 1..9, then 8 RETs -> returns 9,8,...,2; `ras_overflow`=1.
- `pc_out`=0x7FFFF, increment -> 0x00000; `halt` -> `halted`=1, PC frozen 5 cycles; `resume` -> 0x00001.
- `reset` low mid-CALL sequence -> `pc_out`=0, flags 0, subsequent `ret` underflows; with macro undefined, `ret` only increments.
